// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: opcodes and parser states.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPC,
      S_ADDR,
      S_LEN,
      S_DATA_RX,
      S_DATA_WR,
      S_CKSUM
   } state_t;

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_H = 8'h48;

endpackage

// File: rtl/uart_loader.sv
// Host-to-memory boot loader: pops framed commands from uart_rx, writes payload
// bytes to memory and holds/releases the core via cpu_hold/boot_addr.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned TIMEOUT_CLKS = 1_000_000,
   parameter logic        HOLD_ON_RST  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_dout,
   input  logic              rx_full,
   output logic              rx_re,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ready,
   output logic              cpu_hold,
   output logic [ADDR_W-1:0] boot_addr,
   output logic              busy,
   output logic              pkt_done,
   output logic              err_cmd,
   output logic              err_cksum,
   output logic              err_timeout
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);

   state_t            state_q, state_d;
   logic [7:0]        byte_q;
   logic [7:0]        op_q;
   logic [1:0]        cnt_q;
   logic [31:0]       addr_sh;
   logic [15:0]       rem_q;
   logic [7:0]        sum_q;
   logic [TMO_W-1:0]  tmo_cnt;

   logic              rx_pop;
   logic              byte_in;
   logic              counting;
   logic              tmo_hit;
   logic [31:0]       addr_full;
   logic [15:0]       len_full;
   logic              ev_op, ev_done, ev_cmd_err, ev_cksum_err;

   // A popped byte is latched and consumed one clk later, while rx_re is high;
   // this is what places the earliest mem_valid after the rx_re pulse.
   assign byte_in   = rx_re;
   assign rx_pop    = rx_full && !rx_re && (state_q != S_DATA_WR);
   assign counting  = (state_q != S_IDLE) && (state_q != S_DATA_WR);
   assign tmo_hit   = counting && !rx_pop && !byte_in &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));
   assign addr_full = {byte_q, addr_sh[31:8]};
   assign len_full  = {byte_q, rem_q[15:8]};
   assign busy      = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      ev_op        = 1'b0;
      ev_done      = 1'b0;
      ev_cmd_err   = 1'b0;
      ev_cksum_err = 1'b0;
      unique case (state_q)
         S_IDLE:    if (byte_in) state_d = S_OPC;
         S_OPC: begin
            ev_op = 1'b1;
            case (byte_q)
               CMD_W, CMD_G: state_d = S_ADDR;
               CMD_H: begin
                  ev_done = 1'b1;
                  state_d = S_IDLE;
               end
               default: begin
                  ev_cmd_err = 1'b1;
                  state_d    = S_IDLE;
               end
            endcase
         end
         S_ADDR: begin
            if (byte_in && cnt_q == 2'd3) begin
               if (op_q == CMD_W) state_d = S_LEN;
               else begin
                  ev_done = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_LEN: begin
            if (byte_in && cnt_q == 2'd1)
               state_d = (len_full == 16'd0) ? S_CKSUM : S_DATA_RX;
         end
         S_DATA_RX: if (byte_in) state_d = S_DATA_WR;
         S_DATA_WR: begin
            if (mem_ready) state_d = (rem_q == 16'd1) ? S_CKSUM : S_DATA_RX;
         end
         S_CKSUM: begin
            if (byte_in) begin
               state_d = S_IDLE;
               if (byte_q == sum_q) ev_done = 1'b1;
               else                 ev_cksum_err = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (tmo_hit) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_re       <= 1'b0;
         byte_q      <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         addr_sh     <= '0;
         rem_q       <= '0;
         sum_q       <= '0;
         tmo_cnt     <= '0;
         mem_valid   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         cpu_hold    <= HOLD_ON_RST;
         boot_addr   <= '0;
         pkt_done    <= 1'b0;
         err_cmd     <= 1'b0;
         err_cksum   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         rx_re    <= rx_pop;
         pkt_done <= ev_done;
         if (rx_pop) byte_q <= rx_dout;

         if (rx_pop || state_q == S_IDLE) tmo_cnt <= '0;
         else if (counting)               tmo_cnt <= tmo_cnt + TMO_W'(1);

         if (state_d != state_q)                       cnt_q <= '0;
         else if (byte_in && (state_q == S_ADDR || state_q == S_LEN))
                                                       cnt_q <= cnt_q + 2'd1;

         if (ev_op) begin
            op_q        <= byte_q;
            sum_q       <= '0;
            err_cmd     <= ev_cmd_err;
            err_cksum   <= 1'b0;
            err_timeout <= 1'b0;
            if (byte_q == CMD_H) cpu_hold <= 1'b1;
         end
         if (ev_cksum_err) err_cksum <= 1'b1;

         if (state_q == S_ADDR && byte_in) begin
            addr_sh <= addr_full;
            if (cnt_q == 2'd3) begin
               if (op_q == CMD_W) mem_addr <= addr_full[ADDR_W-1:0];
               else begin
                  boot_addr <= addr_full[ADDR_W-1:0];
                  cpu_hold  <= 1'b0;
               end
            end
         end

         if (state_q == S_LEN && byte_in) rem_q <= len_full;

         if (state_q == S_DATA_RX && byte_in) begin
            mem_wdata <= byte_q;
            sum_q     <= sum_q + byte_q;
            mem_valid <= 1'b1;
         end

         if (state_q == S_DATA_WR && mem_ready) begin
            mem_valid <= 1'b0;
            mem_addr  <= mem_addr + ADDR_W'(1);
            rem_q     <= rem_q - 16'd1;
         end

         if (tmo_hit) begin
            mem_valid   <= 1'b0;
            err_timeout <= 1'b1;
         end
      end
   end

endmodule
